axi_nm_xbar: RTL and testbench



---
 rtl/axi_xbar_pkg.sv | 48 ++++
 rtl/axi_rr_arb.sv | 19 +
 rtl/axi_nm_xbar.sv | 274 +++++++++++++++++++++++++++
 tb/tb_axi_nm_xbar.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared types and helpers for the NxM AXI crossbar: response codes, FSM
// encodings, round-robin pick and address window decode.
package axi_xbar_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam int MAX_PORTS = 8;
    localparam int MAX_AW    = 64;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_e;
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR} wr_state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } dec_t;

    // Requests above the real port count are zero, so wrapping mod 8 gives
    // the same winner as wrapping mod NM.
    function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                     input logic [2:0] ptr);
        logic [MAX_PORTS-1:0] gnt;
        logic [2:0]           k;
        gnt = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            k = ptr + 3'(i);
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic dec_t addr_decode(input logic [MAX_AW-1:0] addr,
                                         input logic [MAX_PORTS-1:0][MAX_AW-1:0] base,
                                         input logic [MAX_PORTS-1:0][MAX_AW-1:0] mask,
                                         input int ns);
        dec_t d;
        d = '0;
        for (int j = MAX_PORTS - 1; j >= 0; j--) begin
            if (j < ns && (addr & mask[j]) == base[j]) begin
                d.hit = 1'b1;
                d.idx = 3'(j);
            end
        end
        return d;
    endfunction
endpackage

// File: rtl/axi_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at
// or after the pointer, wrapping.
module axi_rr_arb
    import axi_xbar_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);
    logic [MAX_PORTS-1:0] pick;

    always_comb begin
        pick  = rr_pick(MAX_PORTS'(req_i), 3'(ptr_i));
        gnt_o = pick[N-1:0];
    end
endmodule

// File: rtl/axi_nm_xbar.sv
// NM-master x NS-slave AXI4 crossbar, one transaction in flight per path,
// registered round-robin grants, unmapped addresses answered with DECERR.
module axi_nm_xbar
    import axi_xbar_pkg::*;
#(
    parameter int NM = 2,
    parameter int NS = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4,
    parameter logic [NS*AW-1:0] SLV_BASE = {32'h0000_0000, 32'h0200_0000},
    parameter logic [NS*AW-1:0] SLV_MASK = {32'h0000_0000, 32'hFFFF_0000}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NM-1:0]     m_arvalid,
    output logic [NM-1:0]     m_arready,
    input  logic [NM*AW-1:0]  m_araddr,
    input  logic [NM*IW-1:0]  m_arid,
    input  logic [NM*8-1:0]   m_arlen,
    input  logic [NM*3-1:0]   m_arsize,
    input  logic [NM*2-1:0]   m_arburst,
    output logic [NM-1:0]     m_rvalid,
    input  logic [NM-1:0]     m_rready,
    output logic [DW-1:0]     m_rdata,
    output logic [1:0]        m_rresp,
    output logic              m_rlast,
    output logic [IW-1:0]     m_rid,
    input  logic [NM-1:0]     m_awvalid,
    output logic [NM-1:0]     m_awready,
    input  logic [NM*AW-1:0]  m_awaddr,
    input  logic [NM*IW-1:0]  m_awid,
    input  logic [NM*8-1:0]   m_awlen,
    input  logic [NM*3-1:0]   m_awsize,
    input  logic [NM*2-1:0]   m_awburst,
    input  logic [NM-1:0]     m_wvalid,
    output logic [NM-1:0]     m_wready,
    input  logic [NM*DW-1:0]  m_wdata,
    input  logic [NM*DW/8-1:0] m_wstrb,
    input  logic [NM-1:0]     m_wlast,
    output logic [NM-1:0]     m_bvalid,
    input  logic [NM-1:0]     m_bready,
    output logic [1:0]        m_bresp,
    output logic [IW-1:0]     m_bid,
    output logic [NS-1:0]     s_arvalid,
    input  logic [NS-1:0]     s_arready,
    output logic [AW-1:0]     s_araddr,
    output logic [IW-1:0]     s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic [NS-1:0]     s_rvalid,
    output logic [NS-1:0]     s_rready,
    input  logic [NS*DW-1:0]  s_rdata,
    input  logic [NS*2-1:0]   s_rresp,
    input  logic [NS-1:0]     s_rlast,
    input  logic [NS*IW-1:0]  s_rid,
    output logic [NS-1:0]     s_awvalid,
    input  logic [NS-1:0]     s_awready,
    output logic [AW-1:0]     s_awaddr,
    output logic [IW-1:0]     s_awid,
    output logic [7:0]        s_awlen,
    output logic [2:0]        s_awsize,
    output logic [1:0]        s_awburst,
    output logic [NS-1:0]     s_wvalid,
    input  logic [NS-1:0]     s_wready,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_wstrb,
    output logic              s_wlast,
    input  logic [NS-1:0]     s_bvalid,
    output logic [NS-1:0]     s_bready,
    input  logic [NS*2-1:0]   s_bresp,
    input  logic [NS*IW-1:0]  s_bid
);
    localparam int MIW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SIW = (NS > 1) ? $clog2(NS) : 1;

    function automatic logic [MIW-1:0] oh2idx(input logic [NM-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < NM; i++) if (oh[i]) oh2idx = MIW'(i);
    endfunction

    function automatic logic [MIW-1:0] next_ptr(input logic [MIW-1:0] g);
        return (int'(g) == NM - 1) ? '0 : g + 1'b1;
    endfunction

    logic [MAX_PORTS-1:0][MAX_AW-1:0] win_base, win_mask;
    always_comb begin
        win_base = '0;
        win_mask = '0;
        for (int j = 0; j < NS; j++) begin
            win_base[j] = MAX_AW'(SLV_BASE[j*AW +: AW]);
            win_mask[j] = MAX_AW'(SLV_MASK[j*AW +: AW]);
        end
    end

    // ---------------- read path ----------------
    rd_state_e      rstate_q, rstate_d;
    logic [MIW-1:0] rg_q, rg_d, rptr_q, rptr_d;
    logic [SIW-1:0] rsel_q, rsel_d;
    logic [7:0]     rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [IW-1:0]  rid_q, rid_d;
    logic           racc_q, racc_d;
    logic [NM-1:0]  ar_gnt;
    logic [MIW-1:0] ar_idx;
    dec_t           ar_dec;

    axi_rr_arb #(.N(NM), .PW(MIW)) u_ar_arb (.req_i(m_arvalid), .ptr_i(rptr_q), .gnt_o(ar_gnt));
    assign ar_idx = oh2idx(ar_gnt);
    assign ar_dec = addr_decode(MAX_AW'(m_araddr[ar_idx*AW +: AW]), win_base, win_mask, NS);

    always_comb begin
        rstate_d = rstate_q; rg_d = rg_q; rsel_d = rsel_q; rptr_d = rptr_q;
        rlen_d = rlen_q; rcnt_d = rcnt_q; rid_d = rid_q; racc_d = racc_q;
        m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = RESP_OKAY; m_rlast = 1'b0; m_rid = '0;
        s_arvalid = '0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_rready = '0;
        unique case (rstate_q)
            R_IDLE: if (|m_arvalid) begin
                rg_d     = ar_idx;
                rsel_d   = SIW'(ar_dec.idx);
                racc_d   = 1'b0;
                rcnt_d   = '0;
                rstate_d = ar_dec.hit ? R_ADDR : R_ERR;
            end
            R_ADDR: begin
                s_arvalid[rsel_q] = m_arvalid[rg_q];
                s_araddr  = m_araddr[rg_q*AW +: AW];
                s_arid    = m_arid[rg_q*IW +: IW];
                s_arlen   = m_arlen[rg_q*8 +: 8];
                s_arsize  = m_arsize[rg_q*3 +: 3];
                s_arburst = m_arburst[rg_q*2 +: 2];
                m_arready[rg_q] = s_arready[rsel_q];
                if (m_arvalid[rg_q] && s_arready[rsel_q]) rstate_d = R_DATA;
            end
            R_DATA: begin
                m_rvalid[rg_q]   = s_rvalid[rsel_q];
                s_rready[rsel_q] = m_rready[rg_q];
                m_rdata = s_rdata[rsel_q*DW +: DW];
                m_rresp = s_rresp[rsel_q*2 +: 2];
                m_rlast = s_rlast[rsel_q];
                m_rid   = s_rid[rsel_q*IW +: IW];
                if (s_rvalid[rsel_q] && m_rready[rg_q] && s_rlast[rsel_q]) begin
                    rstate_d = R_IDLE;
                    rptr_d   = next_ptr(rg_q);
                end
            end
            R_ERR: if (!racc_q) begin
                // Swallow the AR ourselves, then play back DECERR beats.
                m_arready[rg_q] = 1'b1;
                if (m_arvalid[rg_q]) begin
                    racc_d = 1'b1;
                    rlen_d = m_arlen[rg_q*8 +: 8];
                    rid_d  = m_arid[rg_q*IW +: IW];
                end
            end else begin
                m_rvalid[rg_q] = 1'b1;
                m_rresp = RESP_DECERR;
                m_rid   = rid_q;
                m_rlast = (rcnt_q == rlen_q);
                if (m_rready[rg_q]) begin
                    if (rcnt_q == rlen_q) begin
                        rstate_d = R_IDLE;
                        rptr_d   = next_ptr(rg_q);
                    end else begin
                        rcnt_d = rcnt_q + 8'd1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE; rg_q <= '0; rsel_q <= '0; rptr_q <= '0;
            rlen_q <= '0; rcnt_q <= '0; rid_q <= '0; racc_q <= 1'b0;
        end else begin
            rstate_q <= rstate_d; rg_q <= rg_d; rsel_q <= rsel_d; rptr_q <= rptr_d;
            rlen_q <= rlen_d; rcnt_q <= rcnt_d; rid_q <= rid_d; racc_q <= racc_d;
        end
    end

    // ---------------- write path ----------------
    wr_state_e      wstate_q, wstate_d;
    logic [MIW-1:0] wg_q, wg_d, wptr_q, wptr_d;
    logic [SIW-1:0] wsel_q, wsel_d;
    logic [IW-1:0]  wid_q, wid_d;
    logic [1:0]     wph_q, wph_d;
    logic [NM-1:0]  aw_gnt;
    logic [MIW-1:0] aw_idx;
    dec_t           aw_dec;

    axi_rr_arb #(.N(NM), .PW(MIW)) u_aw_arb (.req_i(m_awvalid), .ptr_i(wptr_q), .gnt_o(aw_gnt));
    assign aw_idx = oh2idx(aw_gnt);
    assign aw_dec = addr_decode(MAX_AW'(m_awaddr[aw_idx*AW +: AW]), win_base, win_mask, NS);

    always_comb begin
        wstate_d = wstate_q; wg_d = wg_q; wsel_d = wsel_q; wptr_d = wptr_q;
        wid_d = wid_q; wph_d = wph_q;
        m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = RESP_OKAY; m_bid = '0;
        s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_bready = '0;
        unique case (wstate_q)
            W_IDLE: if (|m_awvalid) begin
                wg_d     = aw_idx;
                wsel_d   = SIW'(aw_dec.idx);
                wph_d    = 2'd0;
                wstate_d = aw_dec.hit ? W_ADDR : W_ERR;
            end
            W_ADDR: begin
                s_awvalid[wsel_q] = m_awvalid[wg_q];
                s_awaddr  = m_awaddr[wg_q*AW +: AW];
                s_awid    = m_awid[wg_q*IW +: IW];
                s_awlen   = m_awlen[wg_q*8 +: 8];
                s_awsize  = m_awsize[wg_q*3 +: 3];
                s_awburst = m_awburst[wg_q*2 +: 2];
                m_awready[wg_q] = s_awready[wsel_q];
                if (m_awvalid[wg_q] && s_awready[wsel_q]) wstate_d = W_DATA;
            end
            W_DATA: begin
                s_wvalid[wsel_q] = m_wvalid[wg_q];
                s_wdata = m_wdata[wg_q*DW +: DW];
                s_wstrb = m_wstrb[wg_q*(DW/8) +: DW/8];
                s_wlast = m_wlast[wg_q];
                m_wready[wg_q] = s_wready[wsel_q];
                if (m_wvalid[wg_q] && s_wready[wsel_q] && m_wlast[wg_q]) wstate_d = W_RESP;
            end
            W_RESP: begin
                m_bvalid[wg_q]   = s_bvalid[wsel_q];
                s_bready[wsel_q] = m_bready[wg_q];
                m_bresp = s_bresp[wsel_q*2 +: 2];
                m_bid   = s_bid[wsel_q*IW +: IW];
                if (s_bvalid[wsel_q] && m_bready[wg_q]) begin
                    wstate_d = W_IDLE;
                    wptr_d   = next_ptr(wg_q);
                end
            end
            W_ERR: case (wph_q)
                2'd0: begin
                    m_awready[wg_q] = 1'b1;
                    if (m_awvalid[wg_q]) begin
                        wid_d = m_awid[wg_q*IW +: IW];
                        wph_d = 2'd1;
                    end
                end
                2'd1: begin
                    m_wready[wg_q] = 1'b1;
                    if (m_wvalid[wg_q] && m_wlast[wg_q]) wph_d = 2'd2;
                end
                default: begin
                    m_bvalid[wg_q] = 1'b1;
                    m_bresp = RESP_DECERR;
                    m_bid   = wid_q;
                    if (m_bready[wg_q]) begin
                        wstate_d = W_IDLE;
                        wptr_d   = next_ptr(wg_q);
                    end
                end
            endcase
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE; wg_q <= '0; wsel_q <= '0; wptr_q <= '0;
            wid_q <= '0; wph_q <= '0;
        end else begin
            wstate_q <= wstate_d; wg_q <= wg_d; wsel_q <= wsel_d; wptr_q <= wptr_d;
            wid_q <= wid_d; wph_q <= wph_d;
        end
    end
endmodule

// File: tb/tb_axi_nm_xbar.sv
// Directed bench for axi_nm_xbar: table of single-master reads plus hand
// sequences for contention, burst hold-off, DECERR, writes, overlap and reset.
module tb_axi_nm_xbar;
    localparam int NM = 2, NS = 2, AW = 32, DW = 32, IW = 4;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
    logic [NM*AW-1:0] m_araddr; logic [NM*IW-1:0] m_arid; logic [NM*8-1:0] m_arlen;
    logic [NM*3-1:0] m_arsize; logic [NM*2-1:0] m_arburst;
    logic [DW-1:0] m_rdata; logic [1:0] m_rresp; logic m_rlast; logic [IW-1:0] m_rid;
    logic [NM-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [NM*AW-1:0] m_awaddr; logic [NM*IW-1:0] m_awid; logic [NM*8-1:0] m_awlen;
    logic [NM*3-1:0] m_awsize; logic [NM*2-1:0] m_awburst;
    logic [NM*DW-1:0] m_wdata; logic [NM*DW/8-1:0] m_wstrb;
    logic [1:0] m_bresp; logic [IW-1:0] m_bid;
    logic [NS-1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [AW-1:0] s_araddr; logic [IW-1:0] s_arid; logic [7:0] s_arlen;
    logic [2:0] s_arsize; logic [1:0] s_arburst;
    logic [NS*DW-1:0] s_rdata; logic [NS*2-1:0] s_rresp; logic [NS*IW-1:0] s_rid;
    logic [NS-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [AW-1:0] s_awaddr; logic [IW-1:0] s_awid; logic [7:0] s_awlen;
    logic [2:0] s_awsize; logic [1:0] s_awburst;
    logic [DW-1:0] s_wdata; logic [DW/8-1:0] s_wstrb; logic s_wlast;
    logic [NS*2-1:0] s_bresp; logic [NS*IW-1:0] s_bid;

    // slave 0: bit31 set; slave 1: 0x0200_xxxx; 0x1000_0000 maps nowhere
    axi_nm_xbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .IW(IW),
                  .SLV_BASE(64'h0200_0000_8000_0000), .SLV_MASK(64'hFFFF_0000_8000_0000)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input int m, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        m_arvalid[m] = 1'b1;
        m_araddr[m*AW +: AW] = addr;
        m_arid[m*IW +: IW] = id;
        m_arlen[m*8 +: 8] = len;
        m_arsize[m*3 +: 3] = 3'd2;
        m_arburst[m*2 +: 2] = 2'b01;
    endtask

    // sel 0/1 = expected slave, 2 = unmapped (DECERR)
    task automatic rd_addr(input int m, input int sel, input logic [31:0] addr,
                           input logic [3:0] id, input logic [7:0] len);
        chk("ar_idle_ready", 64'(m_arready), 64'd0);
        tick();
        if (sel < 2) begin
            chk("ar_route", 64'(s_arvalid), 64'd1 << sel);
            chk("ar_addr", 64'(s_araddr), 64'(addr));
            chk("ar_len", 64'(s_arlen), 64'(len));
            chk("ar_id", 64'(s_arid), 64'(id));
        end else begin
            chk("ar_err_novalid", 64'(s_arvalid), 64'd0);
        end
        chk("ar_grant", 64'(m_arready), 64'd1 << m);
        tick();
        m_arvalid[m] = 1'b0;
    endtask

    task automatic rd_data(input int m, input int sel, input logic [3:0] id,
                           input logic [7:0] len, input logic [31:0] base);
        for (int b = 0; b <= int'(len); b++) begin
            if (sel < 2) begin
                s_rvalid = '0;
                s_rvalid[sel] = 1'b1;
                s_rdata[sel*DW +: DW] = base + 32'(b);
                s_rlast[sel] = (b == int'(len));
                s_rid[sel*IW +: IW] = id;
                s_rresp[sel*2 +: 2] = 2'b00;
            end
            m_rready[m] = 1'b1;
            #1;
            chk("r_valid", 64'(m_rvalid), 64'd1 << m);
            chk("r_data", 64'(m_rdata), (sel < 2) ? 64'(base + 32'(b)) : 64'd0);
            chk("r_resp", 64'(m_rresp), (sel < 2) ? 64'd0 : 64'd3);
            chk("r_last", 64'(m_rlast), 64'(b == int'(len)));
            chk("r_id", 64'(m_rid), 64'(id));
            if (sel < 2) chk("r_sready", 64'(s_rready), 64'd1 << sel);
            chk("r_ar_quiet", 64'(s_arvalid), 64'd0);
            chk("r_arready_quiet", 64'(m_arready), 64'd0);
            tick();
        end
        s_rvalid = '0; s_rlast = '0; m_rready = '0;
    endtask

    task automatic wr_txn(input int m, input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input int sel, input logic [31:0] wbase);
        m_awvalid[m] = 1'b1;
        m_awaddr[m*AW +: AW] = addr;
        m_awid[m*IW +: IW] = id;
        m_awlen[m*8 +: 8] = len;
        chk("aw_idle_ready", 64'(m_awready), 64'd0);
        tick();
        chk("aw_route", 64'(s_awvalid), (sel < 2) ? (64'd1 << sel) : 64'd0);
        if (sel < 2) chk("aw_addr", 64'(s_awaddr), 64'(addr));
        chk("aw_grant", 64'(m_awready), 64'd1 << m);
        tick();
        m_awvalid[m] = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            m_wvalid[m] = 1'b1;
            m_wdata[m*DW +: DW] = wbase + 32'(b);
            m_wstrb[m*4 +: 4] = 4'hF;
            m_wlast[m] = (b == int'(len));
            #1;
            chk("w_ready", 64'(m_wready), 64'd1 << m);
            if (sel < 2) begin
                chk("w_route", 64'(s_wvalid), 64'd1 << sel);
                chk("w_data", 64'(s_wdata), 64'(wbase + 32'(b)));
                chk("w_last", 64'(s_wlast), 64'(b == int'(len)));
            end else begin
                chk("w_err_novalid", 64'(s_wvalid), 64'd0);
            end
            tick();
        end
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
        if (sel < 2) begin
            s_bvalid[sel] = 1'b1;
            s_bresp[sel*2 +: 2] = 2'b00;
            s_bid[sel*IW +: IW] = id;
        end
        m_bready[m] = 1'b1;
        #1;
        chk("b_valid", 64'(m_bvalid), 64'd1 << m);
        chk("b_resp", 64'(m_bresp), (sel < 2) ? 64'd0 : 64'd3);
        chk("b_id", 64'(m_bid), 64'(id));
        tick();
        s_bvalid = '0; m_bready = '0;
        chk("b_done", 64'(m_bvalid), 64'd0);
    endtask

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        int          sel;
        logic [31:0] base;
    } rd_vec_t;
    rd_vec_t vecs[6];

    initial begin
        m_arvalid = '0; m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_rready = '0; m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0;
        m_awburst = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
        s_arready = '1; s_rvalid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rid = '0;
        s_awready = '1; s_wready = '1; s_bvalid = '0; s_bresp = '0; s_bid = '0;

        vecs[0] = '{0, 32'h8000_0000, 4'h1, 8'd0, 0, 32'hDEAD_BEEF};
        vecs[1] = '{1, 32'h0200_0004, 4'h2, 8'd0, 1, 32'h1234_0000};
        vecs[2] = '{0, 32'h8000_1000, 4'h3, 8'd2, 0, 32'hA000_0000};
        vecs[3] = '{1, 32'h1000_0000, 4'h5, 8'd1, 2, 32'h0};
        vecs[4] = '{0, 32'h0200_0008, 4'hF, 8'd0, 1, 32'h5A5A_0000};
        vecs[5] = '{1, 32'h8000_2000, 4'h6, 8'd0, 0, 32'h0BAD_F00D};

        // reset state
        tick(); tick();
        chk("rst_arready", 64'(m_arready), 64'd0);
        chk("rst_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
        chk("rst_awready", 64'(m_awready), 64'd0);
        chk("rst_bvalid", 64'(m_bvalid), 64'd0);
        chk("rst_s_araddr", 64'(s_araddr), 64'd0);
        rst = 1'b0;
        tick();

        // table: single-master reads, ends with rr pointer back at 0
        for (int i = 0; i < 6; i++) begin
            set_ar(vecs[i].m, vecs[i].addr, vecs[i].id, vecs[i].len);
            rd_addr(vecs[i].m, vecs[i].sel, vecs[i].addr, vecs[i].id, vecs[i].len);
            rd_data(vecs[i].m, vecs[i].sel, vecs[i].id, vecs[i].len, vecs[i].base);
        end

        // contention with pointer 0: master 0 then master 1
        set_ar(0, 32'h8000_0010, 4'h1, 8'd0);
        set_ar(1, 32'h8000_0020, 4'h2, 8'd0);
        rd_addr(0, 0, 32'h8000_0010, 4'h1, 8'd0);
        chk("cont_m1_pending", 64'(m_arvalid[1]), 64'd1);
        rd_data(0, 0, 4'h1, 8'd0, 32'h1111_0000);
        rd_addr(1, 0, 32'h8000_0020, 4'h2, 8'd0);
        rd_data(1, 0, 4'h2, 8'd0, 32'h2222_0000);

        // burst: master 1 requests during master 0's 4-beat burst
        set_ar(0, 32'h8000_0200, 4'h3, 8'd3);
        rd_addr(0, 0, 32'h8000_0200, 4'h3, 8'd3);
        set_ar(1, 32'h0200_0020, 4'h8, 8'd0);
        rd_data(0, 0, 4'h3, 8'd3, 32'hB000_0000);
        rd_addr(1, 1, 32'h0200_0020, 4'h8, 8'd0);
        rd_data(1, 1, 4'h8, 8'd0, 32'hC000_0000);

        // DECERR beat is held while rready is low (leaves pointer at 1)
        set_ar(0, 32'h1000_0000, 4'h6, 8'd0);
        rd_addr(0, 2, 32'h1000_0000, 4'h6, 8'd0);
        m_rready = '0;
        chk("err_hold_valid0", 64'(m_rvalid), 64'd1);
        tick();
        chk("err_hold_valid1", 64'(m_rvalid), 64'd1);
        chk("err_hold_last", 64'(m_rlast), 64'd1);
        rd_data(0, 2, 4'h6, 8'd0, 32'h0);

        // contention with pointer 1: master 1 first
        set_ar(0, 32'h8000_0030, 4'h9, 8'd0);
        set_ar(1, 32'h8000_0040, 4'hA, 8'd0);
        rd_addr(1, 0, 32'h8000_0040, 4'hA, 8'd0);
        rd_data(1, 0, 4'hA, 8'd0, 32'h3333_0000);
        rd_addr(0, 0, 32'h8000_0030, 4'h9, 8'd0);
        rd_data(0, 0, 4'h9, 8'd0, 32'h4444_0000);

        // writes: slave 0 burst, slave 1 single, unmapped
        wr_txn(0, 32'h8000_0300, 4'h1, 8'd2, 0, 32'h5500_0000);
        wr_txn(1, 32'h0200_0000, 4'h2, 8'd0, 1, 32'h6600_0000);
        wr_txn(1, 32'h1000_0000, 4'h9, 8'd1, 2, 32'h7700_0000);

        // read on master 0 and write on master 1 overlap
        set_ar(0, 32'h8000_0100, 4'h4, 8'd1);
        m_awvalid[1] = 1'b1; m_awaddr[AW +: AW] = 32'h0200_0010; m_awid[IW +: IW] = 4'h7;
        m_awlen[8 +: 8] = 8'd0;
        tick();
        chk("conc_s_arvalid", 64'(s_arvalid), 64'd1);
        chk("conc_s_awvalid", 64'(s_awvalid), 64'd2);
        tick();
        m_arvalid[0] = 1'b0; m_awvalid[1] = 1'b0;
        s_rvalid[0] = 1'b1; s_rdata[0 +: DW] = 32'hC0DE_0000; s_rlast[0] = 1'b0; s_rid[0 +: IW] = 4'h4;
        m_rready[0] = 1'b1;
        m_wvalid[1] = 1'b1; m_wdata[DW +: DW] = 32'hFEED_0001; m_wlast[1] = 1'b1;
        #1;
        chk("conc_rvalid", 64'(m_rvalid), 64'd1);
        chk("conc_rdata", 64'(m_rdata), 64'hC0DE_0000);
        chk("conc_s_wvalid", 64'(s_wvalid), 64'd2);
        chk("conc_s_wdata", 64'(s_wdata), 64'hFEED_0001);
        chk("conc_wready", 64'(m_wready), 64'd2);
        tick();
        m_wvalid[1] = 1'b0; m_wlast[1] = 1'b0;
        s_rdata[0 +: DW] = 32'hC0DE_0001; s_rlast[0] = 1'b1;
        s_bvalid[1] = 1'b1; s_bid[IW +: IW] = 4'h7; s_bresp[2 +: 2] = 2'b00; m_bready[1] = 1'b1;
        #1;
        chk("conc_rlast", 64'(m_rlast), 64'd1);
        chk("conc_bvalid", 64'(m_bvalid), 64'd2);
        chk("conc_bid", 64'(m_bid), 64'd7);
        tick();
        s_rvalid = '0; s_rlast = '0; m_rready = '0; s_bvalid = '0; m_bready = '0;
        chk("conc_r_done", 64'(m_rvalid), 64'd0);
        chk("conc_b_done", 64'(m_bvalid), 64'd0);

        // reset in the middle of a burst
        set_ar(0, 32'h8000_0040, 4'h7, 8'd3);
        rd_addr(0, 0, 32'h8000_0040, 4'h7, 8'd3);
        s_rvalid[0] = 1'b1; s_rdata[0 +: DW] = 32'h9999_0000; s_rlast[0] = 1'b0; m_rready[0] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_rvalid", 64'(m_rvalid), 64'd0);
        chk("midrst_rdata", 64'(m_rdata), 64'd0);
        chk("midrst_s_rready", 64'(s_rready), 64'd0);
        chk("midrst_s_arvalid", 64'(s_arvalid), 64'd0);
        rst = 1'b0;
        s_rvalid = '0; m_rready = '0;
        tick();
        set_ar(1, 32'h0200_0044, 4'hB, 8'd0);
        rd_addr(1, 1, 32'h0200_0044, 4'hB, 8'd0);
        rd_data(1, 1, 4'hB, 8'd0, 32'hAAAA_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
